// File: rtl/wt_dcache_miss_arb.sv
// wt_dcache_miss_arb
// Arbitrates between NumPorts dcache requestors (LD ctrl, PTW, wbuffer, ...)
// and the single miss unit port. Two priority classes, round-robin inside a
// class. Every granted request gets a transaction ID from a small table, so
// each memory return can be routed back to the port that issued it. A flush
// blocks new grants and is acknowledged once the table has drained.
//
// Optional build macro: WT_DCACHE_ARB_AGING_EN
//   When defined, a low-prio port that has waited AgeLimit cycles is
//   promoted to the high-prio class until it is granted.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i / flush_ack_o flush request (held) / one-cycle done pulse
//   port_prio_i           per-port class, 1 = high priority
//   port_req_i            per-port request, held until port_ack_o
//   port_ack_o            one-hot grant pulse, same cycle as latch
//   port_we_i, port_paddr_i, port_wdata_i, port_size_i
//                         per-port request fields, packed port-major
//   port_rtrn_vld_o       one-hot return routed to the owning port
//   miss_req_o/miss_ack_i request handshake towards the miss unit
//   miss_we_o, miss_paddr_o, miss_wdata_o, miss_size_o, miss_id_o
//                         latched request fields and allocated ID
//   rtrn_vld_i, rtrn_id_i memory return
//   spurious_o            pulse: return to an ID that is not outstanding
//   inflight_o            number of PEND + OUT table entries
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | no request held towards the miss unit
//   HOLD     | request held, miss_* stable until miss_ack_i
//   FLUSH    | flush seen, no new grants, waiting for table to drain

module wt_dcache_miss_arb #(
   parameter  int NumPorts   = 4,
   parameter  int PaddrWidth = 56,
   parameter  int DataWidth  = 64,
   parameter  int TxDepth    = 8,
   parameter  int AgeLimit   = 16,
   localparam int IdWidth    = $clog2(TxDepth)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            flush_i,
   output logic                            flush_ack_o,
   input  logic [NumPorts-1:0]             port_prio_i,
   input  logic [NumPorts-1:0]             port_req_i,
   output logic [NumPorts-1:0]             port_ack_o,
   input  logic [NumPorts-1:0]             port_we_i,
   input  logic [NumPorts*PaddrWidth-1:0]  port_paddr_i,
   input  logic [NumPorts*DataWidth-1:0]   port_wdata_i,
   input  logic [NumPorts*3-1:0]           port_size_i,
   output logic [NumPorts-1:0]             port_rtrn_vld_o,
   output logic                            miss_req_o,
   input  logic                            miss_ack_i,
   output logic                            miss_we_o,
   output logic [PaddrWidth-1:0]           miss_paddr_o,
   output logic [DataWidth-1:0]            miss_wdata_o,
   output logic [2:0]                      miss_size_o,
   output logic [IdWidth-1:0]              miss_id_o,
   input  logic                            rtrn_vld_i,
   input  logic [IdWidth-1:0]              rtrn_id_i,
   output logic                            spurious_o,
   output logic [IdWidth:0]                inflight_o
);

   localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [1:0] TX_FREE = 2'd0;
   localparam logic [1:0] TX_PEND = 2'd1;
   localparam logic [1:0] TX_OUT  = 2'd2;

   localparam logic [NumPorts-1:0] PortOne = {{(NumPorts-1){1'b0}}, 1'b1};
   localparam logic [IdWidth:0]    InfOne  = {{IdWidth{1'b0}}, 1'b1};

   logic [1:0]            state_q, state_d;
   logic [1:0]            tx_state_q [TxDepth];
   logic [PortW-1:0]      tx_owner_q [TxDepth];
   logic [PortW-1:0]      rr_q;
   logic                  flush_done_q;
   logic [IdWidth:0]      inflight_q;

   logic                  miss_we_q;
   logic [PaddrWidth-1:0] miss_paddr_q;
   logic [DataWidth-1:0]  miss_wdata_q;
   logic [2:0]            miss_size_q;
   logic [IdWidth-1:0]    miss_id_q;

   logic [NumPorts-1:0]   prio_eff;
   logic [NumPorts-1:0]   hi_req;
   logic [NumPorts-1:0]   elig;
   logic [PortW-1:0]      win_idx;
   logic                  win_found;
   logic [IdWidth-1:0]    free_idx;
   logic                  free_any;
   logic                  latch_en;
   logic                  ack_en;
   logic                  rtrn_hit;
   logic                  flush_pulse;

   logic                  sel_we;
   logic [PaddrWidth-1:0] sel_paddr;
   logic [DataWidth-1:0]  sel_wdata;
   logic [2:0]            sel_size;

`ifdef WT_DCACHE_ARB_AGING_EN
   localparam int AgeW = $clog2(AgeLimit + 1);

   logic [AgeW-1:0]     age_q [NumPorts];
   logic [NumPorts-1:0] aged;

   always_comb begin
      aged = '0;
      for (int i = 0; i < NumPorts; i++) begin
         aged[i] = (age_q[i] == AgeW'(AgeLimit));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumPorts; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumPorts; i++) begin
            if (port_ack_o[i]) begin
               age_q[i] <= '0;
            end else if (port_req_i[i] && !aged[i]) begin
               age_q[i] <= age_q[i] + AgeW'(1);
            end
         end
      end
   end

   assign prio_eff = port_prio_i | aged;
`else
   assign prio_eff = port_prio_i;
`endif

   // Restrict to the high-prio class whenever it has any requestor.
   assign hi_req = port_req_i & prio_eff;
   assign elig   = (|hi_req) ? hi_req : port_req_i;

   // Round-robin: first pass takes ports above rr_q, second pass wraps to
   // port 0..rr_q, so the scan order is rr_q+1, ..., N-1, 0, ..., rr_q.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
         if (!win_found && elig[i] && (PortW'(i) > rr_q)) begin
            win_idx   = PortW'(i);
            win_found = 1'b1;
         end
      end
      for (int i = 0; i < NumPorts; i++) begin
         if (!win_found && elig[i]) begin
            win_idx   = PortW'(i);
            win_found = 1'b1;
         end
      end
   end

   // Lowest-index FREE entry; entries freed by a return this cycle only
   // become visible next cycle.
   always_comb begin
      free_idx = '0;
      free_any = 1'b0;
      for (int i = TxDepth - 1; i >= 0; i--) begin
         if (tx_state_q[i] == TX_FREE) begin
            free_idx = IdWidth'(i);
            free_any = 1'b1;
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_paddr = '0;
      sel_wdata = '0;
      sel_size  = '0;
      for (int i = 0; i < NumPorts; i++) begin
         if (win_idx == PortW'(i)) begin
            sel_we    = port_we_i[i];
            sel_paddr = port_paddr_i[i*PaddrWidth +: PaddrWidth];
            sel_wdata = port_wdata_i[i*DataWidth +: DataWidth];
            sel_size  = port_size_i[i*3 +: 3];
         end
      end
   end

   assign ack_en   = (state_q == ST_HOLD) && miss_ack_i;
   assign latch_en = !flush_i && (|port_req_i) && free_any &&
                     ((state_q == ST_IDLE) || ack_en);

   assign rtrn_hit = rtrn_vld_i && (tx_state_q[rtrn_id_i] == TX_OUT);

   // flush_done_q suppresses a second ack while the same flush_i is held.
   assign flush_pulse = (state_q == ST_FLUSH) && (inflight_q == '0) && !flush_done_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_i)       state_d = ST_FLUSH;
            else if (latch_en) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (miss_ack_i) begin
               if (flush_i)       state_d = ST_FLUSH;
               else if (latch_en) state_d = ST_HOLD;
               else               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (flush_pulse)                   state_d = ST_IDLE;
            else if (flush_done_q && !flush_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         flush_done_q <= 1'b0;
         inflight_q   <= '0;
         miss_we_q    <= 1'b0;
         miss_paddr_q <= '0;
         miss_wdata_q <= '0;
         miss_size_q  <= '0;
         miss_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         flush_done_q <= flush_i ? (flush_done_q | flush_pulse) : 1'b0;
         if (latch_en) begin
            rr_q         <= win_idx;
            miss_we_q    <= sel_we;
            miss_paddr_q <= sel_paddr;
            miss_wdata_q <= sel_wdata;
            miss_size_q  <= sel_size;
            miss_id_q    <= free_idx;
         end
         case ({latch_en, rtrn_hit})
            2'b10:   inflight_q <= inflight_q + InfOne;
            2'b01:   inflight_q <= inflight_q - InfOne;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Latch, ack and return always address distinct entries (FREE, PEND and
   // OUT respectively), so all three may update the table in one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < TxDepth; i++) begin
            tx_state_q[i] <= TX_FREE;
            tx_owner_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < TxDepth; i++) begin
            if (latch_en && (free_idx == IdWidth'(i))) begin
               tx_state_q[i] <= TX_PEND;
               tx_owner_q[i] <= win_idx;
            end else if (ack_en && (miss_id_q == IdWidth'(i)) &&
                         (tx_state_q[i] == TX_PEND)) begin
               tx_state_q[i] <= TX_OUT;
            end else if (rtrn_hit && (rtrn_id_i == IdWidth'(i))) begin
               tx_state_q[i] <= TX_FREE;
            end
         end
      end
   end

   assign port_ack_o      = latch_en ? (PortOne << win_idx) : '0;
   assign port_rtrn_vld_o = rtrn_hit ? (PortOne << tx_owner_q[rtrn_id_i]) : '0;
   assign spurious_o      = rtrn_vld_i && !rtrn_hit;
   assign flush_ack_o     = flush_pulse;
   assign inflight_o      = inflight_q;

   assign miss_req_o   = (state_q == ST_HOLD);
   assign miss_we_o    = miss_we_q;
   assign miss_paddr_o = miss_paddr_q;
   assign miss_wdata_o = miss_wdata_q;
   assign miss_size_o  = miss_size_q;
   assign miss_id_o    = miss_id_q;

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
module tb_wt_dcache_miss_arb;

   localparam int NP = 4;
   localparam int PW = 56;
   localparam int DW = 64;
   localparam int IW = 3;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              flush_ack_o;
   logic [NP-1:0]     port_prio_i;
   logic [NP-1:0]     port_req_i;
   logic [NP-1:0]     port_ack_o;
   logic [NP-1:0]     port_we_i;
   logic [NP*PW-1:0]  port_paddr_i;
   logic [NP*DW-1:0]  port_wdata_i;
   logic [NP*3-1:0]   port_size_i;
   logic [NP-1:0]     port_rtrn_vld_o;
   logic              miss_req_o;
   logic              miss_ack_i;
   logic              miss_we_o;
   logic [PW-1:0]     miss_paddr_o;
   logic [DW-1:0]     miss_wdata_o;
   logic [2:0]        miss_size_o;
   logic [IW-1:0]     miss_id_o;
   logic              rtrn_vld_i;
   logic [IW-1:0]     rtrn_id_i;
   logic              spurious_o;
   logic [IW:0]       inflight_o;

   int tests_run    = 0;
   int tests_failed = 0;

   wt_dcache_miss_arb dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .flush_ack_o     (flush_ack_o),
      .port_prio_i     (port_prio_i),
      .port_req_i      (port_req_i),
      .port_ack_o      (port_ack_o),
      .port_we_i       (port_we_i),
      .port_paddr_i    (port_paddr_i),
      .port_wdata_i    (port_wdata_i),
      .port_size_i     (port_size_i),
      .port_rtrn_vld_o (port_rtrn_vld_o),
      .miss_req_o      (miss_req_o),
      .miss_ack_i      (miss_ack_i),
      .miss_we_o       (miss_we_o),
      .miss_paddr_o    (miss_paddr_o),
      .miss_wdata_o    (miss_wdata_o),
      .miss_size_o     (miss_size_o),
      .miss_id_o       (miss_id_o),
      .rtrn_vld_i      (rtrn_vld_i),
      .rtrn_id_i       (rtrn_id_i),
      .spurious_o      (spurious_o),
      .inflight_o      (inflight_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      flush_i      = 1'b0;
      port_prio_i  = '0;
      port_req_i   = '0;
      port_we_i    = '0;
      port_paddr_i = '0;
      port_wdata_i = '0;
      port_size_i  = '0;
      miss_ack_i   = 1'b0;
      rtrn_vld_i   = 1'b0;
      rtrn_id_i    = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle_inputs();
      #2;
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      #3;
      tests_run++;
      if (miss_req_o !== 1'b0 || port_ack_o !== 4'b0 || flush_ack_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: req=%b ack=%b fack=%b required 0/0000/0", miss_req_o, port_ack_o, flush_ack_o);
      end
      tests_run++;
      if (inflight_o !== 4'd0 || miss_id_o !== 3'd0 || spurious_o !== 1'b0 || port_rtrn_vld_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_misc: infl=%0d id=%0d spur=%b rtrn=%b required all 0", inflight_o, miss_id_o, spurious_o, port_rtrn_vld_o);
      end
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_single_read();
      do_reset();
      port_req_i         = 4'b0010;
      port_paddr_i[PW +: PW] = 56'h8000_0040;
      port_size_i[3 +: 3]    = 3'd3;
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0010) begin
         tests_failed++;
         $display("FAIL single_ack: got %b required 0010", port_ack_o);
      end
      tick();
      port_req_i = '0;
      settle();
      tests_run++;
      if (miss_req_o !== 1'b1 || miss_id_o !== 3'd0 || inflight_o !== 4'd1) begin
         tests_failed++;
         $display("FAIL single_hold: req=%b id=%0d infl=%0d required 1/0/1", miss_req_o, miss_id_o, inflight_o);
      end
      tests_run++;
      if (miss_paddr_o !== 56'h8000_0040 || miss_we_o !== 1'b0 || miss_size_o !== 3'd3) begin
         tests_failed++;
         $display("FAIL single_fields: paddr=%h we=%b size=%0d required 80000040/0/3", miss_paddr_o, miss_we_o, miss_size_o);
      end
      miss_ack_i = 1'b1;
      tick();
      miss_ack_i = 1'b0;
      settle();
      tests_run++;
      if (miss_req_o !== 1'b0 || inflight_o !== 4'd1) begin
         tests_failed++;
         $display("FAIL single_acked: req=%b infl=%0d required 0/1", miss_req_o, inflight_o);
      end
      rtrn_vld_i = 1'b1;
      rtrn_id_i  = 3'd0;
      settle();
      tests_run++;
      if (port_rtrn_vld_o !== 4'b0010 || spurious_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_rtrn: rtrn=%b spur=%b required 0010/0", port_rtrn_vld_o, spurious_o);
      end
      tick();
      rtrn_vld_i = 1'b0;
      settle();
      tests_run++;
      if (inflight_o !== 4'd0 || port_rtrn_vld_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL single_drain: infl=%0d rtrn=%b required 0/0000", inflight_o, port_rtrn_vld_o);
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{1, 2, 3, 0, 1};
      logic [NP-1:0] exp_ack;
      do_reset();
      port_req_i = 4'b1111;
      miss_ack_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         exp_ack = 4'b0001 << order[k];
         tests_run++;
         if (port_ack_o !== exp_ack) begin
            tests_failed++;
            $display("FAIL rr_grant%0d: got %b required %b", k, port_ack_o, exp_ack);
         end
         if (k > 0) begin
            tests_run++;
            if (miss_id_o !== 3'(k - 1) || miss_req_o !== 1'b1) begin
               tests_failed++;
               $display("FAIL rr_id%0d: id=%0d req=%b required %0d/1", k, miss_id_o, miss_req_o, k - 1);
            end
         end
         tick();
      end
      port_req_i = '0;
      settle();
      tests_run++;
      if (miss_id_o !== 3'd4 || port_ack_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL rr_last: id=%0d ack=%b required 4/0000", miss_id_o, port_ack_o);
      end
      tick();
      miss_ack_i = 1'b0;
      settle();
      tests_run++;
      if (miss_req_o !== 1'b0 || inflight_o !== 4'd5) begin
         tests_failed++;
         $display("FAIL rr_end: req=%b infl=%0d required 0/5", miss_req_o, inflight_o);
      end
   endtask

   task automatic test_high_prio();
      do_reset();
      port_prio_i = 4'b0100;
      port_req_i  = 4'b1111;
      port_we_i   = 4'b0100;
      port_wdata_i[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
      miss_ack_i  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         tests_run++;
         if (port_ack_o !== 4'b0100) begin
            tests_failed++;
            $display("FAIL prio_grant%0d: got %b required 0100", k, port_ack_o);
         end
         tick();
      end
      tests_run++;
      if (miss_we_o !== 1'b1 || miss_wdata_o !== 64'hDEAD_BEEF_0000_0002) begin
         tests_failed++;
         $display("FAIL prio_fields: we=%b wdata=%h required 1/deadbeef00000002", miss_we_o, miss_wdata_o);
      end
      port_req_i = '0;
      tick();
      miss_ack_i = 1'b0;
      settle();
   endtask

   task automatic test_table_full();
      do_reset();
      port_req_i = 4'b0001;
      miss_ack_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         settle();
         tests_run++;
         if (port_ack_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL full_fill%0d: got %b required 0001", k, port_ack_o);
         end
         tick();
      end
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0 || inflight_o !== 4'd8 || miss_id_o !== 3'd7) begin
         tests_failed++;
         $display("FAIL full_ninth: ack=%b infl=%0d id=%0d required 0000/8/7", port_ack_o, inflight_o, miss_id_o);
      end
      tick();
      miss_ack_i = 1'b0;
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0 || miss_req_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_idle: ack=%b req=%b required 0000/0", port_ack_o, miss_req_o);
      end
      rtrn_vld_i = 1'b1;
      rtrn_id_i  = 3'd3;
      settle();
      tests_run++;
      if (port_rtrn_vld_o !== 4'b0001 || port_ack_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL full_rtrn: rtrn=%b ack=%b required 0001/0000", port_rtrn_vld_o, port_ack_o);
      end
      tick();
      rtrn_vld_i = 1'b0;
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0001 || inflight_o !== 4'd7) begin
         tests_failed++;
         $display("FAIL full_relatch: ack=%b infl=%0d required 0001/7", port_ack_o, inflight_o);
      end
      tick();
      port_req_i = '0;
      settle();
      tests_run++;
      if (miss_id_o !== 3'd3 || miss_req_o !== 1'b1 || inflight_o !== 4'd8) begin
         tests_failed++;
         $display("FAIL full_reuse: id=%0d req=%b infl=%0d required 3/1/8", miss_id_o, miss_req_o, inflight_o);
      end
      miss_ack_i = 1'b1;
      tick();
      miss_ack_i = 1'b0;
   endtask

   task automatic test_flush();
      do_reset();
      port_req_i = 4'b0001;
      miss_ack_i = 1'b1;
      settle();
      tick();
      tick();
      tick();
      miss_ack_i = 1'b0;
      flush_i    = 1'b1;
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0 || miss_id_o !== 3'd2) begin
         tests_failed++;
         $display("FAIL flush_hold: ack=%b id=%0d required 0000/2", port_ack_o, miss_id_o);
      end
      tick();
      tests_run++;
      if (miss_req_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_stay_hold: req=%b required 1", miss_req_o);
      end
      miss_ack_i = 1'b1;
      settle();
      tests_run++;
      if (port_ack_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL flush_block: ack=%b required 0000", port_ack_o);
      end
      tick();
      miss_ack_i = 1'b0;
      settle();
      tests_run++;
      if (miss_req_o !== 1'b0 || flush_ack_o !== 1'b0 || inflight_o !== 4'd3 || port_ack_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL flush_enter: req=%b fack=%b infl=%0d ack=%b required 0/0/3/0000", miss_req_o, flush_ack_o, inflight_o, port_ack_o);
      end
      for (int id = 0; id < 3; id++) begin
         rtrn_vld_i = 1'b1;
         rtrn_id_i  = 3'(id);
         settle();
         tests_run++;
         if (flush_ack_o !== 1'b0 || port_rtrn_vld_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL flush_drain%0d: fack=%b rtrn=%b required 0/0001", id, flush_ack_o, port_rtrn_vld_o);
         end
         tick();
      end
      rtrn_vld_i = 1'b0;
      settle();
      tests_run++;
      if (flush_ack_o !== 1'b1 || inflight_o !== 4'd0) begin
         tests_failed++;
         $display("FAIL flush_ack: fack=%b infl=%0d required 1/0", flush_ack_o, inflight_o);
      end
      tick();
      tests_run++;
      if (flush_ack_o !== 1'b0 || port_ack_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL flush_once: fack=%b ack=%b required 0/0000", flush_ack_o, port_ack_o);
      end
      tick();
      tests_run++;
      if (flush_ack_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_reenter: fack=%b required 0", flush_ack_o);
      end
      flush_i = 1'b0;
      tick();
      tests_run++;
      if (port_ack_o !== 4'b0001) begin
         tests_failed++;
         $display("FAIL flush_resume: ack=%b required 0001", port_ack_o);
      end
      tick();
      port_req_i = '0;
      miss_ack_i = 1'b1;
      tick();
      miss_ack_i = 1'b0;
   endtask

   task automatic test_spurious();
      do_reset();
      rtrn_vld_i = 1'b1;
      rtrn_id_i  = 3'd5;
      settle();
      tests_run++;
      if (spurious_o !== 1'b1 || port_rtrn_vld_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL spur_free: spur=%b rtrn=%b required 1/0000", spurious_o, port_rtrn_vld_o);
      end
      tick();
      rtrn_vld_i = 1'b0;
      settle();
      tests_run++;
      if (spurious_o !== 1'b0 || inflight_o !== 4'd0) begin
         tests_failed++;
         $display("FAIL spur_after: spur=%b infl=%0d required 0/0", spurious_o, inflight_o);
      end
      port_req_i = 4'b1000;
      tick();
      port_req_i = '0;
      rtrn_vld_i = 1'b1;
      rtrn_id_i  = 3'd0;
      settle();
      tests_run++;
      if (spurious_o !== 1'b1 || port_rtrn_vld_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL spur_pend: spur=%b rtrn=%b required 1/0000", spurious_o, port_rtrn_vld_o);
      end
      tick();
      rtrn_vld_i = 1'b0;
      settle();
      tests_run++;
      if (inflight_o !== 4'd1 || miss_req_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL spur_pend_keep: infl=%0d req=%b required 1/1", inflight_o, miss_req_o);
      end
      miss_ack_i = 1'b1;
      tick();
      miss_ack_i = 1'b0;
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      #1;
      tests_run++;
      if (inflight_o !== 4'd0 || miss_req_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_clear: infl=%0d req=%b required 0/0", inflight_o, miss_req_o);
      end
      rtrn_vld_i = 1'b1;
      rtrn_id_i  = 3'd0;
      settle();
      tests_run++;
      if (spurious_o !== 1'b1 || port_rtrn_vld_o !== 4'b0) begin
         tests_failed++;
         $display("FAIL midrst_spur: spur=%b rtrn=%b required 1/0000", spurious_o, port_rtrn_vld_o);
      end
      tick();
      rtrn_vld_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_high_prio();
      test_table_full();
      test_flush();
      test_spurious();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
